// File: rtl/store_commit_drain_ctrl.sv
// Drain scheduler for the store commit buffer.
// Ages merged entries and issues write-backs to the DCache port.
module store_commit_drain_ctrl #(
  parameter int ENTRIES = 8,
  parameter int IDX_W   = 3,
  parameter int AGE_W   = 4,
  parameter int THRESH  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alloc_valid,
  input  logic [IDX_W-1:0]   alloc_idx,
  input  logic               touch_valid,
  input  logic [IDX_W-1:0]   touch_idx,
  input  logic               fence_req,
  output logic               issue_valid,
  output logic [IDX_W-1:0]   issue_idx,
  input  logic               issue_ready,
  input  logic               resp_valid,
  input  logic [IDX_W-1:0]   resp_idx,
  input  logic [1:0]         resp_kind,
  output logic [ENTRIES-1:0] entry_busy,
  output logic [ENTRIES-1:0] entry_locked,
  output logic               full,
  output logic               fence_done,
  output logic               proto_err
);

  typedef enum logic [1:0] {
    S_FREE,
    S_WAIT,
    S_PEND,
    S_WRITING
  } ent_t;

  typedef enum logic {
    M_NORMAL,
    M_DRAIN
  } mode_t;

  localparam int OCC_W = $clog2(ENTRIES + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;
  localparam logic [1:0] K_OK    = 2'd0;
  localparam logic [1:0] K_RETRY = 2'd1;
  localparam logic [1:0] K_RSVD  = 2'd3;

  ent_t             st  [ENTRIES];
  logic [AGE_W-1:0] age [ENTRIES];

  mode_t              mode;
  logic               thresh_mode;
  logic [ENTRIES-1:0] ready;
  logic               pick_any;
  logic [IDX_W-1:0]   pick_idx;
  logic [OCC_W-1:0]   occ;
  logic               load_en;
  logic               accept;
  logic               resp_act;
  logic               drain_empty;
  logic               alloc_err;
  logic               touch_err;
  logic               resp_err;

  // Per-entry status vectors, occupancy and readiness.
  always_comb begin
    entry_busy   = '0;
    entry_locked = '0;
    ready        = '0;
    occ          = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      entry_busy[i]   = (st[i] != S_FREE);
      entry_locked[i] = (st[i] == S_PEND) ||
                        (st[i] == S_WRITING);
      ready[i]        = (st[i] == S_WAIT) &&
                        ((age[i] == AGE_MAX) ||
                         thresh_mode ||
                         (mode == M_DRAIN));
      occ = occ + OCC_W'(entry_busy[i]);
    end
  end

  // Lowest-index ready entry wins the issue slot.
  always_comb begin
    pick_any = 1'b0;
    pick_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (ready[i]) begin
        pick_any = 1'b1;
        pick_idx = IDX_W'(i);
      end
    end
  end

  assign full        = &entry_busy;
  assign accept      = issue_valid && issue_ready;
  assign load_en     = !issue_valid || issue_ready;
  assign resp_act    = resp_valid && (resp_kind != K_RSVD);
  // An alloc in the same cycle keeps the drain open.
  assign drain_empty = (occ == '0) && !issue_valid &&
                       !alloc_valid;

  // Illegal events: target entry not in the required state.
  always_comb begin
    alloc_err = alloc_valid &&
                (st[alloc_idx] != S_FREE);
    touch_err = touch_valid &&
                (st[touch_idx] != S_WAIT);
    resp_err  = resp_act &&
                (st[resp_idx] != S_WRITING);
  end

  // Entry lifecycle and age counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        st[i]  <= S_FREE;
        age[i] <= '0;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        unique case (st[i])
          S_FREE: begin
            if (alloc_valid &&
                alloc_idx == IDX_W'(i)) begin
              st[i]  <= S_WAIT;
              age[i] <= '0;
            end
          end
          S_WAIT: begin
            if (load_en && pick_any &&
                pick_idx == IDX_W'(i)) begin
              st[i] <= S_PEND;
            end else if (touch_valid &&
                         touch_idx == IDX_W'(i)) begin
              age[i] <= '0;
            end else if (age[i] != AGE_MAX) begin
              age[i] <= age[i] + 1'b1;
            end
          end
          S_PEND: begin
            if (accept &&
                issue_idx == IDX_W'(i)) begin
              st[i] <= S_WRITING;
            end
          end
          S_WRITING: begin
            if (resp_act &&
                resp_idx == IDX_W'(i)) begin
              if (resp_kind == K_RETRY) begin
                st[i]  <= S_WAIT;
                age[i] <= AGE_MAX;
              end else begin
                st[i] <= S_FREE;
              end
            end
          end
        endcase
      end
    end
  end

  // Issue register, mode FSM, threshold and error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_valid <= 1'b0;
      issue_idx   <= '0;
      mode        <= M_NORMAL;
      thresh_mode <= 1'b0;
      fence_done  <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      thresh_mode <= (occ > OCC_W'(THRESH));
      if (alloc_err || touch_err || resp_err) begin
        proto_err <= 1'b1;
      end
      if (load_en) begin
        issue_valid <= pick_any;
        if (pick_any) begin
          issue_idx <= pick_idx;
        end
      end
      fence_done <= 1'b0;
      unique case (mode)
        M_NORMAL: begin
          if (fence_req) begin
            if (drain_empty) begin
              fence_done <= 1'b1;
            end else begin
              mode <= M_DRAIN;
            end
          end
        end
        M_DRAIN: begin
          if (drain_empty) begin
            mode       <= M_NORMAL;
            fence_done <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_commit_drain_ctrl.sv
// Directed bench for store_commit_drain_ctrl.
// Inputs change 1ns after posedge; outputs checked there too.
module tb_store_commit_drain_ctrl;

  logic       clk;
  logic       rst;
  logic       alloc_valid;
  logic [2:0] alloc_idx;
  logic       touch_valid;
  logic [2:0] touch_idx;
  logic       fence_req;
  logic       issue_valid;
  logic [2:0] issue_idx;
  logic       issue_ready;
  logic       resp_valid;
  logic [2:0] resp_idx;
  logic [1:0] resp_kind;
  logic [7:0] entry_busy;
  logic [7:0] entry_locked;
  logic       full;
  logic       fence_done;
  logic       proto_err;

  int checks;
  int failures;

  store_commit_drain_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_valid  (alloc_valid),
    .alloc_idx    (alloc_idx),
    .touch_valid  (touch_valid),
    .touch_idx    (touch_idx),
    .fence_req    (fence_req),
    .issue_valid  (issue_valid),
    .issue_idx    (issue_idx),
    .issue_ready  (issue_ready),
    .resp_valid   (resp_valid),
    .resp_idx     (resp_idx),
    .resp_kind    (resp_kind),
    .entry_busy   (entry_busy),
    .entry_locked (entry_locked),
    .full         (full),
    .fence_done   (fence_done),
    .proto_err    (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input logic [2:0] idx);
    alloc_valid = 1'b1;
    alloc_idx   = idx;
    step();
    alloc_valid = 1'b0;
  endtask

  task automatic do_touch(input logic [2:0] idx);
    touch_valid = 1'b1;
    touch_idx   = idx;
    step();
    touch_valid = 1'b0;
  endtask

  task automatic do_resp(input logic [2:0] idx,
                         input logic [1:0] kind);
    resp_valid = 1'b1;
    resp_idx   = idx;
    resp_kind  = kind;
    step();
    resp_valid = 1'b0;
  endtask

  task automatic do_fence();
    fence_req = 1'b1;
    step();
    fence_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    alloc_valid = 1'b0;
    alloc_idx   = '0;
    touch_valid = 1'b0;
    touch_idx   = '0;
    fence_req   = 1'b0;
    issue_ready = 1'b0;
    resp_valid  = 1'b0;
    resp_idx    = '0;
    resp_kind   = '0;
    step();
    step();

    // reset state
    chk("rst_iv", issue_valid, 0);
    chk("rst_idx", issue_idx, 0);
    chk("rst_busy", entry_busy, 0);
    chk("rst_locked", entry_locked, 0);
    chk("rst_full", full, 0);
    chk("rst_fdone", fence_done, 0);
    chk("rst_perr", proto_err, 0);
    rst = 1'b0;
    step();

    // age drain: ready after 15 ages, issued one later
    do_alloc(3);
    chk("age_busy", entry_busy, 8'h08);
    repeat (15) step();
    chk("age_iv_early", issue_valid, 0);
    step();
    chk("age_iv", issue_valid, 1);
    chk("age_idx", issue_idx, 3);
    chk("age_locked", entry_locked, 8'h08);
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    chk("age_acc_iv", issue_valid, 0);
    chk("age_acc_lock", entry_locked, 8'h08);
    do_resp(3, 2'd0);
    chk("age_free", entry_busy, 0);

    // merge delay: touches keep the entry waiting
    do_alloc(2);
    for (int k = 0; k < 4; k++) begin
      repeat (9) step();
      do_touch(2);
      chk("merge_hold", issue_valid, 0);
    end
    repeat (15) step();
    chk("merge_iv_early", issue_valid, 0);
    step();
    chk("merge_iv", issue_valid, 1);
    chk("merge_idx", issue_idx, 2);
    chk("merge_perr", proto_err, 0);
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    do_resp(2, 2'd2);
    chk("merge_free", entry_busy, 0);

    // threshold: 7 entries force back-to-back issue
    for (int i = 0; i < 7; i++) begin
      do_alloc(3'(i));
    end
    chk("thr_busy", entry_busy, 8'h7f);
    chk("thr_full0", full, 0);
    issue_ready = 1'b1;
    step();
    chk("thr_iv_lat", issue_valid, 0);
    for (int j = 0; j < 7; j++) begin
      step();
      chk("thr_iv", issue_valid, 1);
      chk("thr_idx", issue_idx, j);
    end
    step();
    chk("thr_iv_end", issue_valid, 0);
    chk("thr_locked", entry_locked, 8'h7f);
    chk("thr_full_end", full, 0);
    do_alloc(7);
    chk("thr_full1", full, 1);
    step();
    chk("thr7_iv", issue_valid, 1);
    chk("thr7_idx", issue_idx, 7);
    step();
    issue_ready = 1'b0;
    chk("thr7_acc", issue_valid, 0);
    for (int i = 0; i < 8; i++) begin
      do_resp(3'(i), 2'd0);
    end
    chk("thr_free", entry_busy, 0);
    chk("thr_full_free", full, 0);

    // backpressure and conflict retry
    do_alloc(1);
    repeat (16) step();
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_iv", issue_valid, 1);
      chk("bp_idx", issue_idx, 1);
      chk("bp_lock", entry_locked[1], 1);
    end
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    chk("bp_acc_iv", issue_valid, 0);
    do_resp(1, 2'd1);
    chk("retry_lock", entry_locked[1], 0);
    chk("retry_busy", entry_busy[1], 1);
    step();
    chk("retry_iv", issue_valid, 1);
    chk("retry_idx", issue_idx, 1);
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    do_resp(1, 2'd0);
    chk("retry_free", entry_busy[1], 0);
    chk("retry_perr", proto_err, 0);

    // fence drains young entries in index order
    for (int i = 0; i < 4; i++) begin
      do_alloc(3'(i));
    end
    do_fence();
    chk("fence_iv0", issue_valid, 0);
    issue_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      step();
      chk("fence_iv", issue_valid, 1);
      chk("fence_idx", issue_idx, j);
    end
    step();
    issue_ready = 1'b0;
    chk("fence_iv_end", issue_valid, 0);
    for (int i = 0; i < 4; i++) begin
      do_resp(3'(i), 2'd0);
      chk("fence_wait", fence_done, 0);
    end
    step();
    chk("fence_done", fence_done, 1);
    step();
    chk("fence_pulse", fence_done, 0);

    // fence on an empty buffer
    do_fence();
    chk("efence_done", fence_done, 1);
    step();
    chk("efence_pulse", fence_done, 0);

    // alloc to a busy (PEND) entry
    do_alloc(5);
    repeat (16) step();
    chk("pe_pend_iv", issue_valid, 1);
    chk("pe_perr0", proto_err, 0);
    do_alloc(5);
    chk("pe_alloc", proto_err, 1);
    chk("pe_alloc_lock", entry_locked, 8'h20);
    step();
    chk("pe_sticky", proto_err, 1);
    do_reset();
    chk("pe_rst", proto_err, 0);
    chk("pe_rst_busy", entry_busy, 0);
    chk("pe_rst_iv", issue_valid, 0);

    // touch to a PEND entry
    do_alloc(5);
    repeat (16) step();
    do_touch(5);
    chk("pe_touch", proto_err, 1);
    chk("pe_touch_idx", issue_idx, 5);
    chk("pe_touch_lock", entry_locked, 8'h20);
    do_reset();

    // reserved response ignored; response to FREE flagged
    do_resp(4, 2'd3);
    chk("pe_rsvd", proto_err, 0);
    do_resp(4, 2'd0);
    chk("pe_resp", proto_err, 1);
    chk("pe_resp_busy", entry_busy, 0);
    do_reset();
    chk("pe_rst2", proto_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
